// File: rtl/eth_pixel_receiver_if.sv
// RMII receive pins plus the frame-buffer write / packet status bus of the pixel receiver.
// master = receiver side, slave = PHY/frame-buffer side.
interface eth_pixel_receiver_if;
    logic        crsdv;
    logic [1:0]  rxd;
    logic [16:0] pixel_addr;
    logic [7:0]  pixel_data;
    logic        pixel_valid;
    logic        pkt_done;
    logic        pkt_ok;
    logic [15:0] pkt_index;
    logic        busy;

    modport master (
        input  crsdv, rxd,
        output pixel_addr, pixel_data, pixel_valid, pkt_done, pkt_ok, pkt_index, busy
    );

    modport slave (
        output crsdv, rxd,
        input  pixel_addr, pixel_data, pixel_valid, pkt_done, pkt_ok, pkt_index, busy
    );
endinterface

// File: rtl/eth_pixel_receiver.sv
// RMII pixel-packet receiver: parses MAC/EtherType/index, writes payload pixels into the
// frame buffer and reports a per-packet CRC-checked verdict.
module eth_pixel_receiver #(
    parameter int unsigned PIXELS_PER_PACKET = 960,
    parameter int unsigned FRAME_PIXELS      = 76800,
    parameter logic [15:0] ETHERTYPE         = 16'h88B5,
    parameter logic [47:0] MAC_ADDR          = 48'h020000000002
) (
    input  logic                 clk,
    input  logic                 rst,
    eth_pixel_receiver_if.master bus
);

    typedef enum logic [2:0] {
        StIdle, StPreamble, StHeader, StIndex, StPayload, StFcs, StDrop
    } state_e;

    localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

    state_e      state_q, state_d;
    logic [1:0]  dib_q, dib_d;
    logic [5:0]  sh_q, sh_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic        mac_ok_q, mac_ok_d;
    logic        bc_ok_q, bc_ok_d;
    logic [7:0]  idx_hi_q, idx_hi_d;
    logic [16:0] base_q, base_d;
    logic        in_range_q, in_range_d;
    logic        hdr_q, hdr_d;
    logic [15:0] pkt_index_q, pkt_index_d;
    logic [16:0] pixel_addr_q, pixel_addr_d;
    logic [7:0]  pixel_data_q, pixel_data_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        pkt_done_q, pkt_done_d;
    logic        pkt_ok_q, pkt_ok_d;

    logic        byte_done;
    logic [7:0]  byte_val;
    logic [15:0] idx_full;
    logic [31:0] prod;
    logic [17:0] addr_sum;
    logic [7:0]  mac_byte;
    logic        in_frame;
    logic        rx_state;

    // Reflected CRC-32, two bits per call, LSB first.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r[0] ^ d[i]) ? ({1'b0, r[31:1]} ^ 32'hEDB88320) : {1'b0, r[31:1]};
        end
        return r;
    endfunction

    assign byte_done = bus.crsdv && (dib_q == 2'd3);
    assign byte_val  = {bus.rxd, sh_q};
    assign idx_full  = {idx_hi_q, byte_val};
    assign prod      = 32'(idx_full) * PIXELS_PER_PACKET;
    assign addr_sum  = 18'(base_q) + 18'(cnt_q);
    assign mac_byte  = MAC_ADDR[{3'd5 - cnt_q[2:0], 3'b000} +: 8];
    assign in_frame  = state_q inside {StHeader, StIndex, StPayload, StFcs, StDrop};
    assign rx_state  = state_q inside {StHeader, StIndex, StPayload, StFcs};

    always_comb begin
        state_d       = state_q;
        dib_d         = dib_q;
        sh_d          = sh_q;
        cnt_d         = cnt_q;
        crc_d         = crc_q;
        mac_ok_d      = mac_ok_q;
        bc_ok_d       = bc_ok_q;
        idx_hi_d      = idx_hi_q;
        base_d        = base_q;
        in_range_d    = in_range_q;
        hdr_d         = hdr_q;
        pkt_index_d   = pkt_index_q;
        pixel_addr_d  = pixel_addr_q;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = 1'b0;
        pkt_done_d    = 1'b0;
        pkt_ok_d      = 1'b0;

        if (in_frame && !bus.crsdv) begin
            state_d    = StIdle;
            pkt_done_d = hdr_q;
            pkt_ok_d   = hdr_q && (state_q == StFcs) && (cnt_q == 16'd4) && (dib_q == 2'd0) &&
                         (crc_q == CrcResidue) && in_range_q;
        end else begin
            if (rx_state && bus.crsdv) begin
                dib_d = dib_q + 2'd1;
                sh_d  = {bus.rxd, sh_q[5:2]};
                crc_d = crc_dibit(crc_q, bus.rxd);
            end

            unique case (state_q)
                StIdle: begin
                    hdr_d = 1'b0;
                    if (bus.crsdv && bus.rxd == 2'b01) state_d = StPreamble;
                end
                StPreamble: begin
                    if (!bus.crsdv) begin
                        state_d = StIdle;
                    end else if (bus.rxd == 2'b11) begin
                        state_d  = StHeader;
                        dib_d    = 2'd0;
                        cnt_d    = 16'd0;
                        crc_d    = 32'hFFFFFFFF;
                        mac_ok_d = 1'b1;
                        bc_ok_d  = 1'b1;
                        hdr_d    = 1'b1;
                    end else if (bus.rxd != 2'b01) begin
                        state_d = StDrop;
                    end
                end
                StHeader: begin
                    if (byte_done) begin
                        cnt_d = cnt_q + 16'd1;
                        if (cnt_q < 16'd6) begin
                            mac_ok_d = mac_ok_q && (byte_val == mac_byte);
                            bc_ok_d  = bc_ok_q && (byte_val == 8'hFF);
                            if (!mac_ok_d && !bc_ok_d) state_d = StDrop;
                        end else if (cnt_q == 16'd12) begin
                            if (byte_val != ETHERTYPE[15:8]) state_d = StDrop;
                        end else if (cnt_q == 16'd13) begin
                            if (byte_val != ETHERTYPE[7:0]) begin
                                state_d = StDrop;
                            end else begin
                                state_d = StIndex;
                                cnt_d   = 16'd0;
                            end
                        end
                    end
                end
                StIndex: begin
                    if (byte_done) begin
                        if (cnt_q == 16'd0) begin
                            idx_hi_d = byte_val;
                            cnt_d    = 16'd1;
                        end else begin
                            pkt_index_d = idx_full;
                            base_d      = prod[16:0];
                            in_range_d  = prod < FRAME_PIXELS;
                            state_d     = StPayload;
                            cnt_d       = 16'd0;
                        end
                    end
                end
                StPayload: begin
                    if (byte_done) begin
                        pixel_data_d  = byte_val;
                        pixel_addr_d  = addr_sum[16:0];
                        pixel_valid_d = in_range_q && (32'(addr_sum) < FRAME_PIXELS);
                        if (cnt_q == 16'(PIXELS_PER_PACKET - 1)) begin
                            state_d = StFcs;
                            cnt_d   = 16'd0;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                StFcs: begin
                    // Anything past the 4th FCS byte spoils the frame.
                    if (byte_done) begin
                        if (cnt_q == 16'd4) state_d = StDrop;
                        else cnt_d = cnt_q + 16'd1;
                    end
                end
                StDrop: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            dib_q         <= 2'd0;
            sh_q          <= 6'd0;
            cnt_q         <= 16'd0;
            crc_q         <= 32'hFFFFFFFF;
            mac_ok_q      <= 1'b0;
            bc_ok_q       <= 1'b0;
            idx_hi_q      <= 8'd0;
            base_q        <= 17'd0;
            in_range_q    <= 1'b0;
            hdr_q         <= 1'b0;
            pkt_index_q   <= 16'd0;
            pixel_addr_q  <= 17'd0;
            pixel_data_q  <= 8'd0;
            pixel_valid_q <= 1'b0;
            pkt_done_q    <= 1'b0;
            pkt_ok_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            dib_q         <= dib_d;
            sh_q          <= sh_d;
            cnt_q         <= cnt_d;
            crc_q         <= crc_d;
            mac_ok_q      <= mac_ok_d;
            bc_ok_q       <= bc_ok_d;
            idx_hi_q      <= idx_hi_d;
            base_q        <= base_d;
            in_range_q    <= in_range_d;
            hdr_q         <= hdr_d;
            pkt_index_q   <= pkt_index_d;
            pixel_addr_q  <= pixel_addr_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            pkt_done_q    <= pkt_done_d;
            pkt_ok_q      <= pkt_ok_d;
        end
    end

    assign bus.pixel_addr  = pixel_addr_q;
    assign bus.pixel_data  = pixel_data_q;
    assign bus.pixel_valid = pixel_valid_q;
    assign bus.pkt_done    = pkt_done_q;
    assign bus.pkt_ok      = pkt_ok_q;
    assign bus.pkt_index   = pkt_index_q;
    assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_eth_pixel_receiver.sv
// Self-checking bench for eth_pixel_receiver: table of frame vectors, random frames against a
// frame-level reference model, plus back-to-back and mid-frame reset sequences.
module tb_eth_pixel_receiver;

    localparam logic [47:0] OwnMac   = 48'h020000000002;
    localparam logic [47:0] Bcast    = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] OtherMac = 48'h020000000003;
    localparam int          Npix     = 960;
    localparam int          Fpix     = 76800;

    typedef struct {
        logic [47:0] mac;
        logic [15:0] etype;
        logic [15:0] index;
        bit          flip;
        int          npix;
        int          extra;
        bit          rnd;
        bit          rnd_idx;
        int          exp_n;
        bit          exp_ok;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    eth_pixel_receiver_if bus ();

    eth_pixel_receiver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    logic [24:0] got_w[$];
    logic [24:0] exp_w[$];
    logic [7:0]  frame_q[$];
    logic [7:0]  pix[Npix];
    logic [15:0] model_idx = 16'd0;
    vec_t        vecs[9];

    always @(negedge clk) begin
        if (bus.pixel_valid) got_w.push_back({bus.pixel_addr, bus.pixel_data});
        if (bus.pkt_done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fcs_crc();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 8; i < frame_q.size(); i++) begin
            for (int b = 0; b < 8; b++) begin
                c = (c[0] ^ frame_q[i][b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return c;
    endfunction

    task automatic build(input vec_t v);
        logic [31:0] fcs;
        frame_q.delete();
        for (int k = 0; k < Npix; k++) pix[k] = v.rnd ? 8'($urandom) : 8'(k % 256);
        repeat (7) frame_q.push_back(8'h55);
        frame_q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) frame_q.push_back(v.mac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) frame_q.push_back(8'(i == 0 ? 1 : (i == 5 ? 2 : 0)));
        frame_q.push_back(v.etype[15:8]);
        frame_q.push_back(v.etype[7:0]);
        frame_q.push_back(v.index[15:8]);
        frame_q.push_back(v.index[7:0]);
        for (int k = 0; k < v.npix; k++) frame_q.push_back(pix[k]);
        if (v.npix == Npix) begin
            fcs = ~fcs_crc();
            for (int i = 0; i < 4; i++) frame_q.push_back(fcs[8*i +: 8]);
        end
        if (v.flip) begin
            pix[500] = pix[500] ^ 8'h10;
            frame_q[8 + 16 + 500] = frame_q[8 + 16 + 500] ^ 8'h10;
        end
        repeat (v.extra) frame_q.push_back(8'($urandom));
    endtask

    // Frame-level expectation straight from the packet rules.
    task automatic model(input vec_t v, input int sent, input bit complete, output bit ok);
        bit hdr_ok;
        int base;
        hdr_ok = (v.mac == OwnMac || v.mac == Bcast) && v.etype == 16'h88B5;
        base   = int'(v.index) * Npix;
        if (hdr_ok) model_idx = v.index;
        if (hdr_ok && base < Fpix) begin
            for (int k = 0; k < sent; k++)
                if (base + k < Fpix) exp_w.push_back({17'(base + k), pix[k]});
        end
        ok = hdr_ok && base < Fpix && complete && !v.flip && v.extra == 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) begin
            bus.crsdv = 1'b1;
            bus.rxd   = b[2*i +: 2];
            @(negedge clk);
        end
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) send_byte(frame_q[i]);
    endtask

    task automatic end_frame(input bit eok);
        chk("busy before crsdv fall", 32'(bus.busy), 32'd1);
        bus.crsdv = 1'b0;
        bus.rxd   = 2'b00;
        @(negedge clk);
        chk("pkt_done pulse", 32'(bus.pkt_done), 32'd1);
        chk("pkt_ok verdict", 32'(bus.pkt_ok), 32'(eok));
        chk("busy after end", 32'(bus.busy), 32'd0);
    endtask

    task automatic cmp_writes(input string name, input int wb, input int eb);
        int bad;
        int n;
        bad = 0;
        n = got_w.size() - wb;
        if (exp_w.size() - eb < n) n = exp_w.size() - eb;
        for (int i = 0; i < n; i++) if (got_w[wb + i] !== exp_w[eb + i]) bad++;
        chk(name, 32'(bad), 32'd0);
    endtask

    task automatic run_frame(input vec_t v, input bit use_tbl);
        int wb, eb, db;
        bit mok;
        wb = got_w.size();
        eb = exp_w.size();
        db = done_cnt;
        build(v);
        model(v, v.npix, v.npix == Npix, mok);
        send_bytes(frame_q.size());
        end_frame(use_tbl ? v.exp_ok : mok);
        repeat (3) @(negedge clk);
        chk("write count", 32'(got_w.size() - wb),
            use_tbl ? 32'(v.exp_n) : 32'(exp_w.size() - eb));
        cmp_writes("write addr/data", wb, eb);
        chk("single pkt_done", 32'(done_cnt - db), 32'd1);
        chk("pkt_index", 32'(bus.pkt_index), 32'(model_idx));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " pixel_valid"}, 32'(bus.pixel_valid), 32'd0);
        chk({tag, " pixel_addr"}, 32'(bus.pixel_addr), 32'd0);
        chk({tag, " pixel_data"}, 32'(bus.pixel_data), 32'd0);
        chk({tag, " pkt_done"}, 32'(bus.pkt_done), 32'd0);
        chk({tag, " pkt_ok"}, 32'(bus.pkt_ok), 32'd0);
        chk({tag, " pkt_index"}, 32'(bus.pkt_index), 32'd0);
        chk({tag, " busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        vec_t v;
        vec_t va;
        bit   mok;
        int   wb, eb, db;

        //            mac       etype     index   flip npix extra rnd ridx exp_n ok
        vecs[0] = '{Bcast,    16'h88B5, 16'd3,     0, Npix, 0, 0, 0, 960, 1};
        vecs[1] = '{Bcast,    16'h88B5, 16'd3,     1, Npix, 0, 0, 0, 960, 0};
        vecs[2] = '{Bcast,    16'h0800, 16'd3,     0, Npix, 0, 0, 0, 0,   0};
        vecs[3] = '{Bcast,    16'h88B5, 16'd80,    0, Npix, 0, 1, 0, 0,   0};
        vecs[4] = '{OwnMac,   16'h88B5, 16'd79,    0, Npix, 0, 1, 0, 960, 1};
        vecs[5] = '{OtherMac, 16'h88B5, 16'd1,     0, Npix, 0, 1, 0, 0,   0};
        vecs[6] = '{OwnMac,   16'h88B5, 16'd0,     0, Npix, 0, 1, 1, 960, 1};
        vecs[7] = '{Bcast,    16'h88B5, 16'hFFFF,  0, Npix, 0, 1, 0, 0,   0};
        vecs[8] = '{OwnMac,   16'h88B5, 16'd7,     0, Npix, 1, 1, 0, 960, 0};

        bus.crsdv = 1'b0;
        bus.rxd   = 2'b00;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            if (v.rnd_idx) v.index = 16'($urandom_range(0, 79));
            run_frame(v, 1'b1);
        end

        for (int r = 0; r < 3; r++) begin
            case ($urandom_range(0, 2))
                0: v.mac = OwnMac;
                1: v.mac = Bcast;
                default: v.mac = OtherMac;
            endcase
            v.etype   = ($urandom_range(0, 3) == 0) ? 16'h0800 : 16'h88B5;
            v.index   = 16'($urandom_range(0, 90));
            v.flip    = ($urandom_range(0, 3) == 0);
            v.npix    = Npix;
            v.extra   = 0;
            v.rnd     = 1'b1;
            v.rnd_idx = 1'b0;
            run_frame(v, 1'b0);
        end

        // Truncated frame, then a good frame after exactly one idle cycle.
        wb = got_w.size();
        eb = exp_w.size();
        db = done_cnt;
        va = '{Bcast, 16'h88B5, 16'd5, 0, 100, 0, 1, 0, 100, 0};
        build(va);
        model(va, 100, 1'b0, mok);
        send_bytes(frame_q.size());
        end_frame(1'b0);
        v = '{OwnMac, 16'h88B5, 16'd6, 0, Npix, 0, 1, 0, 960, 1};
        build(v);
        model(v, Npix, 1'b1, mok);
        send_bytes(frame_q.size());
        end_frame(1'b1);
        repeat (3) @(negedge clk);
        chk("b2b write count", 32'(got_w.size() - wb), 32'd1060);
        cmp_writes("b2b addr/data", wb, eb);
        chk("b2b pkt_done count", 32'(done_cnt - db), 32'd2);
        chk("b2b pkt_index", 32'(bus.pkt_index), 32'd6);

        // Reset after 500 payload pixels.
        wb = got_w.size();
        eb = exp_w.size();
        db = done_cnt;
        v = '{Bcast, 16'h88B5, 16'd2, 0, Npix, 0, 1, 0, 500, 0};
        build(v);
        model(v, 500, 1'b0, mok);
        send_bytes(8 + 16 + 500);
        rst       = 1'b1;
        bus.crsdv = 1'b1;
        bus.rxd   = 2'b10;
        @(negedge clk);
        chk_all_zero("mid-frame reset");
        bus.crsdv = 1'b0;
        bus.rxd   = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        model_idx = 16'd0;
        chk("reset write count", 32'(got_w.size() - wb), 32'd500);
        cmp_writes("reset addr/data", wb, eb);
        chk("reset no pkt_done", 32'(done_cnt - db), 32'd0);
        chk("reset idle", 32'(bus.busy), 32'd0);

        run_frame(vecs[0], 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
